// File: rtl/pipe_hazard_ctrl_pkg.sv
// rtl/pipe_hazard_ctrl_pkg.sv - shared types and constants for the pipeline sequencing controller
//
// Package pipe_ctrl_pkg:
//   ctrl_state_t          controller state: RUN, MEM_WAIT, DRAIN, HALTED
//   NOP_INSTR             encoding loaded into IF/ID on a flush
//   NREG_BITS_DEFAULT     default register-address width (8 GPRs)

package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        DRAIN    = 2'd2,
        HALTED   = 2'd3
    } ctrl_state_t;

    localparam logic [15:0] NOP_INSTR = 16'h4000;

    localparam int NREG_BITS_DEFAULT = 3;

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// rtl/pipe_hazard_ctrl_hazard_detect.sv - combinational load-use hazard compare
//
// Ports:
//   id_rs_addr, id_rt_addr   source register fields of the instruction in ID
//   id_uses_rs, id_uses_rt   ID instruction actually reads that source
//   ex_mem_read              instruction in EX is a load
//   ex_rd_addr               destination register of the EX instruction
//   load_use                 ID needs a value the EX load has not produced yet

module hazard_detect
    import pipe_ctrl_pkg::*;
#(
    parameter int NREG_BITS = NREG_BITS_DEFAULT
) (
    input  logic [NREG_BITS-1:0] id_rs_addr,
    input  logic [NREG_BITS-1:0] id_rt_addr,
    input  logic                 id_uses_rs,
    input  logic                 id_uses_rt,
    input  logic                 ex_mem_read,
    input  logic [NREG_BITS-1:0] ex_rd_addr,
    output logic                 load_use
);

    logic rs_hit;
    logic rt_hit;

    // R0 is hardwired to zero, so a load "targeting" R0 never feeds a consumer.
    assign rs_hit = id_uses_rs && (id_rs_addr == ex_rd_addr) && (id_rs_addr != '0);
    assign rt_hit = id_uses_rt && (id_rt_addr == ex_rd_addr) && (id_rt_addr != '0);

    assign load_use = ex_mem_read && (rs_hit || rt_hit);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - pipeline sequencing controller: stalls, flushes, memory waits, halt drain
//
// Optional feature macro: PIPE_HAZARD_PERF_EN (adds stall_cnt / flush_cnt outputs)
//
// Ports:
//   clk, rst_n                     clock (rising edge), asynchronous active-low reset
//   id_rs_addr, id_rt_addr         ID source register fields
//   id_uses_rs, id_uses_rt         ID source-use flags
//   ex_mem_read, ex_rd_addr        EX load flag and destination
//   id_branch_taken                branch/jump resolved taken in ID
//   imem_ready                     fetched word valid this cycle
//   dmem_busy                      data memory not done, MEM must hold
//   if_halt, wb_halt               HALT seen in IF / reached WB
//   pc_wen, ifid_wen               PC and IF/ID write enables
//   ifid_flush                     IF/ID captures NOP_INSTR instead of fetched data
//   idex_bubble                    ID/EX captures all-zero control
//   back_wen                       EX/MEM and MEM/WB write enable
//   halted, halt_err               core stopped; sticky drain timeout
//   stall_cnt, flush_cnt           saturating performance counters (PIPE_HAZARD_PERF_EN only)

module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int NREG_BITS = NREG_BITS_DEFAULT,
    parameter int DRAIN_MAX = 15
`ifdef PIPE_HAZARD_PERF_EN
    ,
    parameter int CNT_W     = 16
`endif
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREG_BITS-1:0] id_rs_addr,
    input  logic [NREG_BITS-1:0] id_rt_addr,
    input  logic                 id_uses_rs,
    input  logic                 id_uses_rt,
    input  logic                 ex_mem_read,
    input  logic [NREG_BITS-1:0] ex_rd_addr,
    input  logic                 id_branch_taken,
    input  logic                 imem_ready,
    input  logic                 dmem_busy,
    input  logic                 if_halt,
    input  logic                 wb_halt,
    output logic                 pc_wen,
    output logic                 ifid_wen,
    output logic                 ifid_flush,
    output logic                 idex_bubble,
    output logic                 back_wen,
    output logic                 halted,
    output logic                 halt_err
`ifdef PIPE_HAZARD_PERF_EN
    ,
    output logic [CNT_W-1:0]     stall_cnt,
    output logic [CNT_W-1:0]     flush_cnt
`endif
);

    localparam int DCW = $clog2(DRAIN_MAX + 1);
    localparam logic [DCW-1:0] DMAX = DCW'(DRAIN_MAX);

    ctrl_state_t    state;
    ctrl_state_t    state_nxt;
    ctrl_state_t    eff_state;
    logic           ret_drain;
    logic           ret_drain_nxt;
    logic [DCW-1:0] drain_cnt;
    logic [DCW-1:0] drain_cnt_nxt;
    logic           err_set;
    logic           branch_flush;
    logic           load_use;

    hazard_detect #(
        .NREG_BITS (NREG_BITS)
    ) u_hazard_detect (
        .id_rs_addr  (id_rs_addr),
        .id_rt_addr  (id_rt_addr),
        .id_uses_rs  (id_uses_rs),
        .id_uses_rt  (id_uses_rt),
        .ex_mem_read (ex_mem_read),
        .ex_rd_addr  (ex_rd_addr),
        .load_use    (load_use)
    );

    always_comb begin
        pc_wen        = 1'b0;
        ifid_wen      = 1'b0;
        ifid_flush    = 1'b0;
        idex_bubble   = 1'b0;
        back_wen      = 1'b0;
        halted        = 1'b0;
        state_nxt     = state;
        ret_drain_nxt = ret_drain;
        drain_cnt_nxt = drain_cnt;
        err_set       = 1'b0;
        branch_flush  = 1'b0;

        // The cycle memory releases behaves exactly like the state being
        // returned to, so no extra cycle is lost on the way out of a wait.
        eff_state = state;
        if (state == MEM_WAIT && !dmem_busy) begin
            eff_state = ret_drain ? DRAIN : RUN;
        end

        case (eff_state)
            RUN: begin
                pc_wen    = 1'b1;
                ifid_wen  = 1'b1;
                back_wen  = 1'b1;
                state_nxt = RUN;
                if (dmem_busy) begin
                    pc_wen        = 1'b0;
                    ifid_wen      = 1'b0;
                    back_wen      = 1'b0;
                    state_nxt     = MEM_WAIT;
                    ret_drain_nxt = 1'b0;
                end else if (load_use) begin
                    pc_wen      = 1'b0;
                    ifid_wen    = 1'b0;
                    idex_bubble = 1'b1;
                end else if (id_branch_taken) begin
                    // Anything in IF (including a HALT) is wrong-path here.
                    ifid_flush   = 1'b1;
                    branch_flush = 1'b1;
                end else if (!imem_ready) begin
                    pc_wen     = 1'b0;
                    ifid_flush = 1'b1;
                end else if (if_halt) begin
                    // HALT is allowed into IF/ID, but fetch stops behind it.
                    pc_wen        = 1'b0;
                    state_nxt     = DRAIN;
                    drain_cnt_nxt = '0;
                end
            end
            DRAIN: begin
                ifid_wen   = 1'b1;
                ifid_flush = 1'b1;
                back_wen   = 1'b1;
                state_nxt  = DRAIN;
                drain_cnt_nxt = (drain_cnt == DMAX) ? drain_cnt : drain_cnt + DCW'(1);
                if (dmem_busy) begin
                    ifid_wen      = 1'b0;
                    back_wen      = 1'b0;
                    state_nxt     = MEM_WAIT;
                    ret_drain_nxt = 1'b1;
                end else begin
                    if (load_use) begin
                        ifid_wen    = 1'b0;
                        idex_bubble = 1'b1;
                    end
                    if (wb_halt) begin
                        state_nxt = HALTED;
                    end else if (drain_cnt == DMAX) begin
                        err_set   = 1'b1;
                        state_nxt = HALTED;
                    end
                end
            end
            HALTED: begin
                halted = 1'b1;
            end
            default: begin
                // MEM_WAIT still busy: everything frozen, defaults apply.
            end
        endcase

        // Reset overrides are combinational so they take hold between edges.
        if (!rst_n) begin
            pc_wen      = 1'b0;
            ifid_wen    = 1'b0;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            back_wen    = 1'b0;
            halted      = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RUN;
            ret_drain <= 1'b0;
            drain_cnt <= '0;
            halt_err  <= 1'b0;
        end else begin
            state     <= state_nxt;
            ret_drain <= ret_drain_nxt;
            drain_cnt <= drain_cnt_nxt;
            if (err_set) begin
                halt_err <= 1'b1;
            end
        end
    end

`ifdef PIPE_HAZARD_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if ((state == RUN || state == MEM_WAIT) && !pc_wen && stall_cnt != '1) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (branch_flush && flush_cnt != '1) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - self-checking bench for pipe_hazard_ctrl

module tb_pipe_hazard_ctrl;

    localparam int DMAX   = 15;
    localparam int S_RUN  = 0;
    localparam int S_WAIT = 1;
    localparam int S_DRN  = 2;
    localparam int S_HLT  = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] id_rs_addr, id_rt_addr, ex_rd_addr;
    logic       id_uses_rs, id_uses_rt, ex_mem_read, id_branch_taken;
    logic       imem_ready, dmem_busy, if_halt, wb_halt;
    logic       pc_wen, ifid_wen, ifid_flush, idex_bubble, back_wen, halted, halt_err;
`ifdef PIPE_HAZARD_PERF_EN
    logic [15:0] stall_cnt, flush_cnt;
`endif

    pipe_hazard_ctrl dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .id_rs_addr      (id_rs_addr),
        .id_rt_addr      (id_rt_addr),
        .id_uses_rs      (id_uses_rs),
        .id_uses_rt      (id_uses_rt),
        .ex_mem_read     (ex_mem_read),
        .ex_rd_addr      (ex_rd_addr),
        .id_branch_taken (id_branch_taken),
        .imem_ready      (imem_ready),
        .dmem_busy       (dmem_busy),
        .if_halt         (if_halt),
        .wb_halt         (wb_halt),
        .pc_wen          (pc_wen),
        .ifid_wen        (ifid_wen),
        .ifid_flush      (ifid_flush),
        .idex_bubble     (idex_bubble),
        .back_wen        (back_wen),
        .halted          (halted),
        .halt_err        (halt_err)
`ifdef PIPE_HAZARD_PERF_EN
        ,
        .stall_cnt       (stall_cnt),
        .flush_cnt       (flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: mode, wait-return target, drain cycles seen, sticky error, counters.
    int m_st, n_st, m_cnt, n_cnt, m_stall, n_stall, m_flush, n_flush;
    bit m_ret, n_ret, m_err, n_err;
    bit e_pc, e_ifid, e_flush, e_bub, e_back, e_halted, e_err;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_st = S_RUN; m_ret = 0; m_cnt = 0; m_err = 0; m_stall = 0; m_flush = 0;
    endtask

    task automatic model_eval();
        bit lu;
        int mode;
        lu = ex_mem_read &&
             ((id_uses_rs && id_rs_addr == ex_rd_addr && id_rs_addr != 0) ||
              (id_uses_rt && id_rt_addr == ex_rd_addr && id_rt_addr != 0));
        e_pc = 0; e_ifid = 0; e_flush = 0; e_bub = 0; e_back = 0; e_halted = 0;
        e_err = m_err;
        n_st = m_st; n_ret = m_ret; n_cnt = m_cnt; n_err = m_err;
        n_stall = m_stall; n_flush = m_flush;
        mode = m_st;
        if (m_st == S_WAIT && !dmem_busy) mode = m_ret ? S_DRN : S_RUN;
        if (mode == S_RUN) begin
            e_pc = 1; e_ifid = 1; e_back = 1;
            if (dmem_busy) begin
                e_pc = 0; e_ifid = 0; e_back = 0; n_st = S_WAIT; n_ret = 0;
            end else if (lu) begin
                e_pc = 0; e_ifid = 0; e_bub = 1; n_st = S_RUN;
            end else if (id_branch_taken) begin
                e_flush = 1; n_st = S_RUN;
                if (m_flush < 65535) n_flush = m_flush + 1;
            end else if (!imem_ready) begin
                e_pc = 0; e_flush = 1; n_st = S_RUN;
            end else if (if_halt) begin
                e_pc = 0; n_st = S_DRN; n_cnt = 0;
            end else begin
                n_st = S_RUN;
            end
        end else if (mode == S_DRN) begin
            e_ifid = 1; e_flush = 1; e_back = 1;
            n_cnt = (m_cnt < DMAX) ? m_cnt + 1 : DMAX;
            if (dmem_busy) begin
                e_ifid = 0; e_back = 0; n_st = S_WAIT; n_ret = 1;
            end else begin
                if (lu) begin e_ifid = 0; e_bub = 1; end
                if (wb_halt) n_st = S_HLT;
                else if (m_cnt == DMAX) begin n_err = 1; n_st = S_HLT; end
                else n_st = S_DRN;
            end
        end else if (mode == S_HLT) begin
            e_halted = 1;
        end
        if ((m_st == S_RUN || m_st == S_WAIT) && !e_pc && m_stall < 65535) n_stall = m_stall + 1;
        if (!rst_n) begin
            e_pc = 0; e_ifid = 0; e_flush = 1; e_bub = 1; e_back = 0; e_halted = 0; e_err = 0;
        end
    endtask

    task automatic compare_all();
        if (!rst_n) model_reset();
        model_eval();
        chk("pc_wen", 32'(pc_wen), 32'(e_pc));
        chk("ifid_wen", 32'(ifid_wen), 32'(e_ifid));
        chk("ifid_flush", 32'(ifid_flush), 32'(e_flush));
        chk("idex_bubble", 32'(idex_bubble), 32'(e_bub));
        chk("back_wen", 32'(back_wen), 32'(e_back));
        chk("halted", 32'(halted), 32'(e_halted));
        chk("halt_err", 32'(halt_err), 32'(e_err));
`ifdef PIPE_HAZARD_PERF_EN
        chk("stall_cnt", 32'(stall_cnt), 32'(m_stall));
        chk("flush_cnt", 32'(flush_cnt), 32'(m_flush));
`endif
    endtask

    // Inputs are driven just after a falling edge; checks sit 1 time unit later.
    task automatic tick_eval();
        #1;
        compare_all();
    endtask

    task automatic tick_adv();
        @(posedge clk);
        if (rst_n) begin
            m_st = n_st; m_ret = n_ret; m_cnt = n_cnt; m_err = n_err;
            m_stall = n_stall; m_flush = n_flush;
        end else begin
            model_reset();
        end
        @(negedge clk);
    endtask

    task automatic idle();
        id_rs_addr = 0; id_rt_addr = 0; ex_rd_addr = 0;
        id_uses_rs = 0; id_uses_rt = 0; ex_mem_read = 0; id_branch_taken = 0;
        imem_ready = 1; dmem_busy = 0; if_halt = 0; wb_halt = 0;
    endtask

    task automatic do_reset();
        rst_n = 0; idle();
        tick_eval();
        tick_adv();
        rst_n = 1;
    endtask

    initial begin
        idle();
        model_reset();
        @(negedge clk);

        // Reset values.
        tick_eval();
        chk("rst_pc_wen", 32'(pc_wen), 32'd0);
        chk("rst_ifid_flush", 32'(ifid_flush), 32'd1);
        chk("rst_idex_bubble", 32'(idex_bubble), 32'd1);
        chk("rst_halted", 32'(halted), 32'd0);
        tick_adv();
        rst_n = 1;

        tick_eval();
        chk("run_pc_wen", 32'(pc_wen), 32'd1);
        tick_adv();

        // Load-use on rs=R3, then the same with R0.
        ex_mem_read = 1; ex_rd_addr = 3; id_rs_addr = 3; id_uses_rs = 1;
        tick_eval();
        chk("lu_pc_wen", 32'(pc_wen), 32'd0);
        chk("lu_ifid_wen", 32'(ifid_wen), 32'd0);
        chk("lu_bubble", 32'(idex_bubble), 32'd1);
        tick_adv();
        ex_rd_addr = 0; id_rs_addr = 0;
        tick_eval();
        chk("lu_r0_pc_wen", 32'(pc_wen), 32'd1);
        chk("lu_r0_bubble", 32'(idex_bubble), 32'd0);
        tick_adv();

        // Branch wins over a wrong-path HALT.
        idle(); id_branch_taken = 1; if_halt = 1;
        tick_eval();
        chk("br_pc_wen", 32'(pc_wen), 32'd1);
        chk("br_flush", 32'(ifid_flush), 32'd1);
        tick_adv();
        idle();
        tick_eval();
        chk("br_still_run", 32'(pc_wen), 32'd1);
        chk("br_not_halted", 32'(halted), 32'd0);
        tick_adv();

        // Three-cycle data memory wait.
        for (int i = 0; i < 3; i++) begin
            dmem_busy = 1;
            tick_eval();
            chk("mw_pc_wen", 32'(pc_wen), 32'd0);
            chk("mw_ifid_wen", 32'(ifid_wen), 32'd0);
            chk("mw_back_wen", 32'(back_wen), 32'd0);
            tick_adv();
        end
        dmem_busy = 0;
        tick_eval();
        chk("mw_exit_pc", 32'(pc_wen), 32'd1);
        chk("mw_exit_back", 32'(back_wen), 32'd1);
        tick_adv();

        // Halt drain: if_halt at cycle 0, wb_halt at cycle 4.
        if_halt = 1;
        tick_eval();
        chk("hd0_pc_wen", 32'(pc_wen), 32'd0);
        chk("hd0_ifid_wen", 32'(ifid_wen), 32'd1);
        chk("hd0_flush", 32'(ifid_flush), 32'd0);
        tick_adv();
        for (int i = 1; i <= 4; i++) begin
            idle(); wb_halt = (i == 4);
            tick_eval();
            chk("hd_flush", 32'(ifid_flush), 32'd1);
            chk("hd_pc_wen", 32'(pc_wen), 32'd0);
            tick_adv();
        end
        idle();
        tick_eval();
        chk("hd_halted", 32'(halted), 32'd1);
        chk("hd_halt_err", 32'(halt_err), 32'd0);
        tick_adv();
        do_reset();

        // Drain timeout.
        if_halt = 1;
        tick_eval();
        tick_adv();
        idle();
        for (int i = 1; i <= 16; i++) begin
            tick_eval();
            chk("to_not_halted", 32'(halted), 32'd0);
            tick_adv();
        end
        tick_eval();
        chk("to_halted", 32'(halted), 32'd1);
        chk("to_halt_err", 32'(halt_err), 32'd1);
        tick_adv();
        do_reset();

        // Asynchronous reset in the middle of a memory wait.
        dmem_busy = 1;
        tick_eval();
        tick_adv();
        tick_eval();
        #2;
        rst_n = 0;
        #1;
        chk("ar_pc_wen", 32'(pc_wen), 32'd0);
        chk("ar_flush", 32'(ifid_flush), 32'd1);
        chk("ar_bubble", 32'(idex_bubble), 32'd1);
        chk("ar_back_wen", 32'(back_wen), 32'd0);
        compare_all();
        @(posedge clk);
        model_reset();
        @(negedge clk);
        rst_n = 1; idle();
        tick_eval();
        chk("ar_release_pc", 32'(pc_wen), 32'd1);
`ifdef PIPE_HAZARD_PERF_EN
        chk("ar_stall_cnt", 32'(stall_cnt), 32'd0);
`endif
        tick_adv();

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            id_rs_addr      = 3'($urandom_range(0, 3));
            id_rt_addr      = 3'($urandom_range(0, 3));
            ex_rd_addr      = 3'($urandom_range(0, 3));
            id_uses_rs      = ($urandom_range(0, 99) < 60);
            id_uses_rt      = ($urandom_range(0, 99) < 60);
            ex_mem_read     = ($urandom_range(0, 99) < 40);
            id_branch_taken = ($urandom_range(0, 99) < 15);
            imem_ready      = ($urandom_range(0, 99) < 85);
            dmem_busy       = ($urandom_range(0, 99) < 12);
            if_halt         = ($urandom_range(0, 99) < 6);
            wb_halt         = ($urandom_range(0, 99) < 8);
            rst_n           = !(m_st == S_HLT && $urandom_range(0, 7) == 0);
            tick_eval();
            tick_adv();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central sequencing controller for the 16-bit five-stage pipeline.
- Generates write-enables and flush/bubble controls for the PC, the IF/ID register and the ID/EX register.
- Also freezes the back end (EX/MEM, MEM/WB) during data-memory waits.
- Resolves load-use stalls, taken-branch flushes, instruction-fetch waits and halt draining, and reports the halted state to the testbench.

Parameters:
- NREG_BITS, 3, register-address width (8 GPRs; R0 reads as zero, so it never causes a hazard).
- DRAIN_MAX, 15, maximum cycles allowed in DRAIN before halt_err is flagged.
- CNT_W, 16, width of the stall performance counter (optional feature).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- id_rs_addr  in  NREG_BITS  rs field of the instruction in ID.
- id_rt_addr  in  NREG_BITS  rt field of the instruction in ID.
- id_uses_rs  in  1  ID instruction reads rs.
- id_uses_rt  in  1  ID instruction reads rt.
- ex_mem_read  in  1  instruction in EX is a load.
- ex_rd_addr  in  NREG_BITS  destination register of the EX instruction.
- id_branch_taken  in  1  branch/jump resolved taken in ID.
- imem_ready  in  1  instruction memory returned a valid word this cycle.
- dmem_busy  in  1  data memory is not done; MEM must hold.
- if_halt  in  1  HALT opcode present in IF.
- wb_halt  in  1  HALT reached WB.
- pc_wen  out  1  PC register write enable.
- ifid_wen  out  1  IF/ID write enable.
- ifid_flush  out  1  IF/ID loads NOP (16'h4000) instead of fetched data; only meaningful when ifid_wen=1.
- idex_bubble  out  1  ID/EX loads all-zero control (bubble).
- back_wen  out  1  EX/MEM and MEM/WB write enable.
- halted  out  1  core stopped.
- halt_err  out  1  drain timeout; sticky.

Behaviour:
- Outputs are combinational from the registered state plus current inputs, so each decision takes effect in the same cycle.
- State is a 2-bit register: RUN, MEM_WAIT, DRAIN, HALTED. Registers also hold ret_drain (1 bit) and drain_cnt (4 bits).
- load_use = ex_mem_read & ((id_uses_rs & rs==ex_rd_addr & rs!=0) | (id_uses_rt & rt==ex_rd_addr & rt!=0)).
- While rst_n=0: state=RUN, drain_cnt=0, ret_drain=0, halt_err=0; outputs forced to pc_wen=0, ifid_wen=0, ifid_flush=1, idex_bubble=1, back_wen=0, halted=0.
- Reset asserted mid-DRAIN or mid-MEM_WAIT aborts the operation immediately.
- RUN default: pc_wen=1, ifid_wen=1, ifid_flush=0, idex_bubble=0, back_wen=1. Priority, highest first:
  - dmem_busy: all wen=0, bubble=0; next=MEM_WAIT, ret_drain=0.
  - load_use: pc_wen=0, ifid_wen=0, idex_bubble=1; back_wen=1; stay RUN.
  - id_branch_taken: pc_wen=1 (target), ifid_flush=1. A simultaneous if_halt is wrong-path and ignored; stay RUN.
  - !imem_ready: pc_wen=0, ifid_flush=1. A simultaneous if_halt is ignored, because the fetched word is invalid.
  - if_halt (with imem_ready): pc_wen=0, ifid_wen=1, no flush, so HALT enters IF/ID; next=DRAIN, drain_cnt=0.
- MEM_WAIT: pc_wen=ifid_wen=back_wen=0, bubble=0. When dmem_busy=0, this cycle's outputs are those of the return state (RUN or DRAIN per ret_drain), and next=that state.
- DRAIN:
  - pc_wen=0 always; ifid_wen=1 with ifid_flush=1.
  - dmem_busy → MEM_WAIT with ret_drain=1.
  - load_use → ifid_wen=0, idex_bubble=1.
  - id_branch_taken and if_halt are ignored.
  - drain_cnt increments every DRAIN cycle except MEM_WAIT cycles; it saturates at DRAIN_MAX.
  - wb_halt → HALTED.
  - drain_cnt==DRAIN_MAX and !wb_halt → halt_err=1 and next=HALTED.
- HALTED: all wen=0, halted=1. Terminal until reset; all inputs are ignored.

Optional Feature:
- Macro: PIPE_HAZARD_PERF_EN.
- When defined, adds outputs stall_cnt[CNT_W-1:0] and flush_cnt[CNT_W-1:0], both reset to 0 and saturating at all-ones.
  - stall_cnt increments each cycle pc_wen=0 in RUN or MEM_WAIT.
  - flush_cnt increments each taken-branch flush.
- When undefined, the ports and logic are absent and behaviour is otherwise identical.

Decomposition:
- Shared package pipe_ctrl_pkg:
  - state enum RUN=2'd0, MEM_WAIT=2'd1, DRAIN=2'd2, HALTED=2'd3.
  - NOP_INSTR=16'h4000.
  - NREG_BITS default.
- One natural sub-module, hazard_detect: combinational load_use compare, reusable by the forwarding unit.
- FSM, drain counter and counters stay in the top module.

Test Plan:
- Load-use: ex_mem_read=1, ex_rd_addr=3, id_rs_addr=3, id_uses_rs=1 → one cycle with pc_wen=0, ifid_wen=0, idex_bubble=1. Same with rd=0 → no stall.
- Branch vs halt: id_branch_taken=1 and if_halt=1 together → pc_wen=1, ifid_flush=1, state stays RUN, halted never rises.
- Memory wait: dmem_busy high for 3 cycles in RUN → pc_wen=ifid_wen=back_wen=0 for exactly 3 cycles, then normal enables on the 4th.
- Halt drain: if_halt at cycle 0, wb_halt at cycle 4 → pc_wen=0 from cycle 0, ifid_flush=1 in cycles 1-4, halted=1 from cycle 5, halt_err=0.
- Timeout: if_halt, wb_halt never asserted → halt_err=1 and halted=1 after 16 DRAIN cycles (DRAIN_MAX=15).
- Async reset: drop rst_n mid-MEM_WAIT between clock edges → outputs go to reset values immediately. After release: RUN, pc_wen=1. With PIPE_HAZARD_PERF_EN, stall_cnt=0.
